unsaved_buttons_in: RTL



---
 rtl/unsaved_buttons_in.sv | 99 +++++++++
 1 files changed

// File: rtl/unsaved_buttons_in.sv
// Avalon-MM button/switch input port: per-bit synchroniser and debouncer, readable
// level, edge-capture register with write-1-to-clear, and a maskable level interrupt.
module unsaved_buttons_in #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] accept, set_bits, clr_bits;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic             wr;
  logic             unused_wdata;

  // Only the low WIDTH bits of writedata carry meaning.
  assign unused_wdata = ^writedata;

  assign wr = chipselect && !write_n;

  // Debounce: a new level at s2 must persist DEBOUNCE_CYCLES cycles; any return
  // to the stable level restarts the count.
  always_comb begin
    stable_d = stable_q;
    accept   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s2_q[i];
          accept[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    set_bits = '0;
    case (EDGE_TYPE)
      0:       set_bits = accept & s2_q;
      1:       set_bits = accept & ~s2_q;
      default: set_bits = accept;
    endcase
    clr_bits = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    mask_d   = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
    // A set in the same cycle as a clear of that bit keeps the bit set.
    cap_d    = (cap_q & ~clr_bits) | set_bits;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= RESET_VALUE;
      s2_q     <= RESET_VALUE;
      stable_q <= RESET_VALUE;
      mask_q   <= '0;
      cap_q    <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q     <= in_port;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      mask_q   <= mask_d;
      cap_q    <= cap_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = stable_q;
      2'd2:    readdata[WIDTH-1:0] = mask_q;
      2'd3:    readdata[WIDTH-1:0] = cap_q;
      default: readdata = '0;
    endcase
  end

  assign irq = |(cap_q & mask_q);

endmodule
